multicycle_sequencer: RTL
=========================

Name: multicycle_sequencer

Overview:
Multi-cycle control FSM for the 60-bit processor. It fetches an instruction over a shared req/ack memory port, decodes the 6-bit opcode in IR[59:54], and steps the datapath through execute, memory and writeback, driving the per-state control strobes. It sits between the instruction register/PC logic and the datapath muxes, ALU, register file and memory interface. It adds a memory-ack timeout and illegal-opcode fault handling.

Parameters:
OPCODE_W, 6, opcode width (IR[59:54])
MEM_TIMEOUT, 15, cycles to wait for mem_ack in FETCH/MEM before faulting (≥1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
run  in  1  enable sequencing; sampled in IDLE and at retire
op  in  6  opcode from IR[59:54]; valid in DECODE
zero  in  1  ALU zero flag, used in EXEC of BRANCH
mem_ack  in  1  memory completion; ignored outside FETCH/MEM
mem_req  out  1  memory request, held until ack
mem_we  out  1  memory write (STORE in MEM only)
iord  out  1  address select: 0=PC, 1=ALU result
ir_write  out  1  load IR
pc_write  out  1  load PC
pc_src  out  2  0=PC+1, 1=branch target, 2=jump target
alu_src  out  1  0=register B, 1=immediate
alu_op  out  2  00=addr add, 01=add, 10=sub, 11=compare
reg_write  out  1  register file write enable
reg_dst  out  1  1=rd field, 0=rt field
mem_to_reg  out  1  writeback source: 1=memory data
busy  out  1  high in any state except IDLE/HALT
instr_retired  out  1  one-cycle pulse on an instruction's final cycle
fault  out  1  sticky; high in HALT
fault_code  out  2  00=none, 01=illegal opcode, 10=mem timeout

Behaviour:
- Reset (async, rst_n=0): state=IDLE, op_q=0, timeout count=0, fault_code=00. All outputs 0 while reset is asserted and in IDLE.
- Outputs are combinational from state, op_q, zero and mem_ack. Any strobe not listed for a state is 0.
- Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 LOAD, 4 STORE, 5 BRANCH, 6 JUMP. Values 7..63 are illegal.
- IDLE: run=1 -> FETCH.
- FETCH: mem_req=1, iord=0.
  - mem_ack=1: ir_write=1, pc_write=1, pc_src=0 (same cycle as ack); next state DECODE.
- DECODE: one cycle; op_q<=op.
  - Illegal op -> HALT, fault_code=01.
  - NOP -> retire.
  - All other legal ops -> EXEC.
- EXEC by op_q:
  - ADD: alu_op=01, alu_src=0; -> WB.
  - SUB: alu_op=10, alu_src=0; -> WB.
  - LOAD/STORE: alu_op=00, alu_src=1; -> MEM.
  - BRANCH: alu_op=11, pc_src=1, pc_write=zero; retire.
  - JUMP: pc_src=2, pc_write=1; retire.
- MEM: mem_req=1, iord=1, mem_we=(op_q==STORE).
  - mem_ack with STORE -> retire.
  - mem_ack with LOAD -> WB.
- WB: reg_write=1; retire.
  - ADD/SUB: reg_dst=1.
  - LOAD: mem_to_reg=1, reg_dst=0.
- Retire: instr_retired=1 in that cycle. Next state is FETCH if run=1, else IDLE.
- run deasserted mid-instruction: the instruction completes; then IDLE.
- Latency with ack in the first FETCH cycle: NOP 2, BRANCH/JUMP 3, ADD/SUB/STORE 4, LOAD 5 cycles. Each ack-wait cycle adds 1.
- Timeout:
  - 4-bit counter clears on entry to FETCH/MEM and increments each FETCH/MEM cycle without ack.
  - Reaching MEM_TIMEOUT with no ack -> HALT, fault_code=10; mem_req drops the next cycle.
  - Ack in the same cycle the limit is reached: ack wins, no fault.
- HALT: all strobes 0, fault=1, busy=0. Exit only via rst_n.
- Reset mid-instruction: immediate abort to IDLE, and no pulse on any strobe.

Decomposition:
- Shared package cpu60_pkg holds:
  - opcode constants (OP_NOP..OP_JUMP)
  - state encoding (IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT)
  - ALU_OP_*, PC_SRC_* and FAULT_* codes
- Later datapath blocks and the bench share these.
- One sub-module, mem_timeout_counter (clear, enable, limit -> expired), instantiated once.

Test Plan:
- ADD (op=1), ack in first FETCH cycle, run=1 -> ir_write and pc_write at cycle 1, alu_op=01 at cycle 3, reg_write=1 with reg_dst=1 and instr_retired=1 at cycle 4, then FETCH.
- LOAD (op=3), ack delayed 3 cycles in MEM -> mem_req=1 with iord=1 and mem_we=0 for 4 cycles, then WB with mem_to_reg=1; total 8 cycles.
- BRANCH (op=5): zero=1 -> pc_write=1 with pc_src=1 in EXEC. Repeat with zero=0 -> pc_write=0. Both retire in 3 cycles.
- op=7 in DECODE -> HALT, fault=1, fault_code=01, busy=0. Outputs stay 0 for 20 further cycles until rst_n=0 clears the fault.
- No ack in FETCH -> after 15 cycles HALT with fault_code=10. Separate run with ack on cycle 15 exactly -> no fault, DECODE follows.
- rst_n pulsed low during MEM of STORE -> all outputs 0 immediately and state IDLE. After release with run=1, FETCH begins on the next edge.

Source files
------------

// File: rtl/cpu60_pkg.sv
// Shared definitions for the 60-bit processor: opcodes, sequencer states,
// and the control/fault encodings used by the sequencer and datapath blocks.
package cpu60_pkg;

    localparam int OPCODE_W = 6;

    localparam logic [5:0] OP_NOP    = 6'd0;
    localparam logic [5:0] OP_ADD    = 6'd1;
    localparam logic [5:0] OP_SUB    = 6'd2;
    localparam logic [5:0] OP_LOAD   = 6'd3;
    localparam logic [5:0] OP_STORE  = 6'd4;
    localparam logic [5:0] OP_BRANCH = 6'd5;
    localparam logic [5:0] OP_JUMP   = 6'd6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_t;

    localparam logic [1:0] ALU_OP_ADDR = 2'b00;
    localparam logic [1:0] ALU_OP_ADD  = 2'b01;
    localparam logic [1:0] ALU_OP_SUB  = 2'b10;
    localparam logic [1:0] ALU_OP_CMP  = 2'b11;

    localparam logic [1:0] PC_SRC_INC    = 2'd0;
    localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

    function automatic logic is_legal_op(input logic [5:0] opcode);
        return opcode <= OP_JUMP;
    endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts consecutive memory-wait cycles; expired_o flags the cycle on which
// the limit is reached so the sequencer can fault unless ack arrives then.
module mem_timeout_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear_i,
    input  logic       enable_i,
    input  logic [3:0] limit_i,
    output logic       expired_o
);

    logic [3:0] count_q;
    logic [3:0] count_d;

    // count_q holds the number of earlier unacknowledged cycles in this wait.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = 4'd0;
        end else if (enable_i && !expired_o) begin
            count_d = count_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == (limit_i - 4'd1));

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM: fetch over req/ack, decode, execute, memory and
// writeback, with memory-ack timeout and illegal-opcode faults into HALT.
module multicycle_sequencer
    import cpu60_pkg::*;
#(
    parameter int OPCODE_W    = 6,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    input  logic [OPCODE_W-1:0] op,
    input  logic                zero,
    input  logic                mem_ack,
    output logic                mem_req,
    output logic                mem_we,
    output logic                iord,
    output logic                ir_write,
    output logic                pc_write,
    output logic [1:0]          pc_src,
    output logic                alu_src,
    output logic [1:0]          alu_op,
    output logic                reg_write,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                busy,
    output logic                instr_retired,
    output logic                fault,
    output logic [1:0]          fault_code
);

    localparam logic [3:0] TIMEOUT_LIMIT = 4'(MEM_TIMEOUT);

    state_t              state_q, state_d;
    logic [OPCODE_W-1:0] op_q, op_d;
    logic [1:0]          fault_q, fault_d;
    logic                memWait;
    logic                expired;
    logic                retire;

    assign memWait = (state_q == ST_FETCH) || (state_q == ST_MEM);

    mem_timeout_counter u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (!memWait || mem_ack),
        .enable_i  (memWait && !mem_ack),
        .limit_i   (TIMEOUT_LIMIT),
        .expired_o (expired)
    );

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        fault_d       = fault_q;
        retire        = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_src        = PC_SRC_INC;
        alu_src       = 1'b0;
        alu_op        = ALU_OP_ADDR;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        instr_retired = 1'b0;
        busy          = (state_q != ST_IDLE) && (state_q != ST_HALT);
        fault         = (state_q == ST_HALT);
        fault_code    = fault_q;

        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = ST_DECODE;
                end else if (expired) begin
                    state_d = ST_HALT;
                    fault_d = FAULT_TIMEOUT;
                end
            end
            ST_DECODE: begin
                op_d = op;
                if (!is_legal_op(op)) begin
                    state_d = ST_HALT;
                    fault_d = FAULT_ILLEGAL;
                end else if (op == OP_NOP) begin
                    retire = 1'b1;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (op_q)
                    OP_ADD: begin
                        alu_op  = ALU_OP_ADD;
                        state_d = ST_WB;
                    end
                    OP_SUB: begin
                        alu_op  = ALU_OP_SUB;
                        state_d = ST_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_op  = ALU_OP_ADDR;
                        alu_src = 1'b1;
                        state_d = ST_MEM;
                    end
                    OP_BRANCH: begin
                        alu_op   = ALU_OP_CMP;
                        pc_src   = PC_SRC_BRANCH;
                        pc_write = zero;
                        retire   = 1'b1;
                    end
                    OP_JUMP: begin
                        pc_src   = PC_SRC_JUMP;
                        pc_write = 1'b1;
                        retire   = 1'b1;
                    end
                    default: begin
                        state_d = ST_HALT;
                        fault_d = FAULT_ILLEGAL;
                    end
                endcase
            end
            ST_MEM: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = (op_q == OP_STORE);
                if (mem_ack) begin
                    if (op_q == OP_STORE) begin
                        retire = 1'b1;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (expired) begin
                    state_d = ST_HALT;
                    fault_d = FAULT_TIMEOUT;
                end
            end
            ST_WB: begin
                reg_write = 1'b1;
                if (op_q == OP_LOAD) begin
                    mem_to_reg = 1'b1;
                end else begin
                    reg_dst = 1'b1;
                end
                retire = 1'b1;
            end
            ST_HALT: begin
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // run is only looked at on the final cycle, so clearing it mid-flight
        // lets the current instruction finish before parking in IDLE.
        if (retire) begin
            instr_retired = 1'b1;
            state_d       = run ? ST_FETCH : ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            fault_q <= FAULT_NONE;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            fault_q <= fault_d;
        end
    end

endmodule
